multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle rework of the MIPS R2000 core.
- Sequences a shared datapath: one memory for instructions and data, the ALU reused for PC+4 and branch targets, plus IR, A/B and ALUOut holding registers.
- Decodes OpCode/Funct from the IR and drives per-state datapath controls.
- Handshakes with a variable-latency memory and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter InstrCount

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous reset, active-high
OpCode  input  6  IR[31:26]
Funct  input  6  IR[5:0]
Zero  input  1  ALU zero flag (combinational, current cycle)
MemReady  input  1  memory completes the access in this cycle
PCWrite  output  1  load PC this cycle
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load IR from memory data
RegDst  output  1  write register: 0 = rt, 1 = rd
Mem2Reg  output  1  write data: 0 = ALUOut, 1 = MDR
RegWrite  output  1  GPR write enable
ALUSrcA  output  1  0 = PC, 1 = A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
ExtOp  output  1  1 = sign extend, 0 = zero extend
ALUOp  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT, 0101 SLL, 0110 SRL
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}
Illegal  output  1  one-cycle pulse on unsupported OpCode/Funct
State  output  4  current state encoding, for debug
InstrCount  output  CNT_W  retired instruction count

Behaviour:
- Reset:
  - RST high at a clock edge puts State in RESET (0) and clears InstrCount to 0.
  - In RESET all control outputs are 0.
  - RESET always proceeds to FETCH on the next edge.
  - RST mid-instruction abandons the instruction; no partial write is asserted after that edge.
- Outputs are Moore decodes of State. Exceptions: PCWrite/IRWrite (gated by MemReady) and PCWrite in BRANCH (gated by Zero).
- Any control not listed for a state is 0.
- States, encoding, outputs and transitions:
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
    - IRWrite=PCWrite=MemReady.
    - Holds until MemReady=1, then goes to DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUOp=ADD (branch target into ALUOut). Next state by OpCode:
    - 000000 (R): EXEC if Funct is supported, else Illegal=1 and FETCH.
    - 100011 lw / 101011 sw: MEMADR.
    - 000100 beq: BRANCH.
    - 000010 j: JUMP.
    - 001001 addiu / 001101 ori: IEXEC.
    - Any other OpCode: Illegal=1, go to FETCH.
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=ADD. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(4): MemRead=1, IorD=1. Holds until MemReady, then MEMWB.
  - MEMWB(5): RegWrite=1, RegDst=0, Mem2Reg=1. Goes to FETCH.
  - MEMWR(6): MemWrite=1, IorD=1. Holds until MemReady, then FETCH.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00. ALUOp from Funct:
    - 100001 → ADD, 100011 → SUB, 100100 → AND, 100101 → OR.
    - 101010 → SLT, 000000 → SLL, 000010 → SRL.
    - Goes to ALUWB.
  - ALUWB(8): RegWrite=1, RegDst=1, Mem2Reg=0. Goes to FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01, PCWrite=Zero. Goes to FETCH.
  - JUMP(10): PCSource=10, PCWrite=1. Goes to FETCH.
  - IEXEC(11): ALUSrcA=1, ALUSrcB=10. addiu: ExtOp=1, ALUOp=ADD. ori: ExtOp=0, ALUOp=OR. Goes to IWB.
  - IWB(12): RegWrite=1, RegDst=0, Mem2Reg=0. Goes to FETCH.
  - Encodings 13–15: unreachable. If entered, go to FETCH with all outputs 0.
- Memory handshake:
  - MemRead/MemWrite are held high continuously while waiting.
  - IorD and ALU selects stay stable.
  - Completion is the first cycle with MemReady=1; there is no timeout.
  - MemReady in states not listed above is ignored.
- InstrCount:
  - Increments by 1 on the edge leaving MEMWB, MEMWR (on MemReady), ALUWB, BRANCH (taken or not), JUMP or IWB.
  - Illegal instructions are not counted.
  - Wraps modulo 2^CNT_W.
- Cycle counts with MemReady always 1:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - Each extra wait cycle adds 1.

Test Plan:
- Reset then MemReady=1, OpCode=000000, Funct=100001 → states 0,1,2,7,8,1; ALUWB has RegWrite=1, RegDst=1; InstrCount=1 after 5 edges.
- lw (100011) with MemReady low for 3 cycles in MEMRD → MemRead=1, IorD=1 held for 4 cycles; no RegWrite until MEMWB; Mem2Reg=1 there.
- beq with Zero=1 → PCWrite=1, PCSource=01 in BRANCH. Repeat with Zero=0 → PCWrite=0, still counted.
- OpCode=111111, and R-type with Funct=001000 → Illegal pulses for one cycle in DECODE, next state FETCH, InstrCount unchanged.
- RST asserted in MEMWR with MemReady=0 → next cycle State=0, MemWrite=0, InstrCount=0, then FETCH.
- CNT_W=4: retire 17 instructions → InstrCount=1 (wrap); ori → ExtOp=0, ALUOp=0011 in IEXEC.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : multicycle_ctrl_if
// Brief    : Control/status bundle between the multicycle MIPS controller and
//            its shared datapath / memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    // Datapath/memory status into the controller
    logic [5:0]       OpCode;
    logic [5:0]       Funct;
    logic             Zero;
    logic             MemReady;

    // Datapath controls out of the controller
    logic             PCWrite;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDst;
    logic             Mem2Reg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             ExtOp;
    logic [3:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             Illegal;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    // Controller side
    modport slave (
        input  OpCode, Funct, Zero, MemReady,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, Mem2Reg,
               RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSource, Illegal,
               State, InstrCount
    );

    // Datapath side
    modport master (
        output OpCode, Funct, Zero, MemReady,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, Mem2Reg,
               RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALUOp, PCSource, Illegal,
               State, InstrCount
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : multicycle_ctrl
// Brief    : Main control FSM of the multicycle MIPS R2000 core. Sequences the
//            shared memory/ALU datapath, handshakes with variable-latency
//            memory and counts retired instructions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    multicycle_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;

    localparam logic [3:0] c_ALU_ADD = 4'b0000;
    localparam logic [3:0] c_ALU_SUB = 4'b0001;
    localparam logic [3:0] c_ALU_AND = 4'b0010;
    localparam logic [3:0] c_ALU_OR  = 4'b0011;
    localparam logic [3:0] c_ALU_SLT = 4'b0100;
    localparam logic [3:0] c_ALU_SLL = 4'b0101;
    localparam logic [3:0] c_ALU_SRL = 4'b0110;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_retire;
    logic             w_funct_ok;
    logic [3:0]       w_funct_alu;

    // R-type function decode: supported flag and the ALU operation it selects
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = c_ALU_ADD;
        case (bus.Funct)
            6'b100001: w_funct_alu = c_ALU_ADD;
            6'b100011: w_funct_alu = c_ALU_SUB;
            6'b100100: w_funct_alu = c_ALU_AND;
            6'b100101: w_funct_alu = c_ALU_OR;
            6'b101010: w_funct_alu = c_ALU_SLT;
            6'b000000: w_funct_alu = c_ALU_SLL;
            6'b000010: w_funct_alu = c_ALU_SRL;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    // State register and retired-instruction counter; reset abandons any
    // instruction in flight without counting it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_RESET;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Next-state and per-state datapath controls (Moore, except the
    // MemReady-gated PC/IR loads in FETCH and the Zero-gated PC load in BRANCH)
    always_comb begin
        w_next       = S_FETCH;
        w_retire     = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.RegDst   = 1'b0;
        bus.Mem2Reg  = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ExtOp    = 1'b0;
        bus.ALUOp    = c_ALU_ADD;
        bus.PCSource = 2'b00;
        bus.Illegal  = 1'b0;
        case (r_state)
            S_RESET: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 computed by the ALU while the instruction is read
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
                w_next      = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                bus.ALUSrcB = 2'b11;
                bus.ExtOp   = 1'b1;
                case (bus.OpCode)
                    c_OP_RTYPE: begin
                        if (w_funct_ok) begin
                            w_next = S_EXEC;
                        end else begin
                            bus.Illegal = 1'b1;
                        end
                    end
                    c_OP_LW, c_OP_SW:     w_next = S_MEMADR;
                    c_OP_BEQ:             w_next = S_BRANCH;
                    c_OP_J:               w_next = S_JUMP;
                    c_OP_ADDIU, c_OP_ORI: w_next = S_IEXEC;
                    default:              bus.Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ExtOp   = 1'b1;
                w_next      = (bus.OpCode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                w_next      = bus.MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                w_retire     = bus.MemReady;
                w_next       = bus.MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = w_funct_alu;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                w_retire     = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUOp    = c_ALU_SUB;
                bus.PCSource = 2'b01;
                bus.PCWrite  = bus.Zero;
                w_retire     = 1'b1;
            end
            S_JUMP: begin
                bus.PCSource = 2'b10;
                bus.PCWrite  = 1'b1;
                w_retire     = 1'b1;
            end
            S_IEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                if (bus.OpCode == c_OP_ORI) begin
                    bus.ALUOp = c_ALU_OR;
                end else begin
                    bus.ExtOp = 1'b1;
                end
                w_next = S_IWB;
            end
            S_IWB: begin
                bus.RegWrite = 1'b1;
                w_retire     = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign bus.State      = r_state;
    assign bus.InstrCount = r_count;

endmodule

`default_nettype wire
